rv32_mod_decode_stage: RTL and testbench

Registered instruction-decode stage with a parcel-alignment buffer. It accepts 32-bit fetch words and re-aligns a mixed stream of 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle a word boundary. Each instruction is decoded into register indices, a format vector, a func code and flags, and is presented with its PC over a valid/ready handshake. It sits between the fetch unit and execute, and supports flush/redirect.

---
 rtl/rv32_mod_decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_rv32_mod_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_decode_stage.sv
// Instruction-decode stage: a parcel-alignment buffer that re-aligns 16/32-bit RV32
// instructions out of 32-bit fetch words, feeding a registered decoder with valid/ready output.
module rv32_mod_decode_stage #(
  parameter int          PARCEL_DEPTH = 4,
  parameter bit          ENABLE_C     = 1'b1,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_word,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic [4:0]  rf_read0_index,
  output logic [4:0]  rf_read1_index,
  output logic [4:0]  rf_write0_index,
  output logic [5:0]  instruction_format,
  output logic [5:0]  func,
  output logic        is_mem_or_io,
  output logic        is_compressed,
  output logic        is_illegal
);
  localparam int CW = $clog2(PARCEL_DEPTH + 1);

  logic [15:0]   parcel_reg  [PARCEL_DEPTH];
  logic [15:0]   parcel_next [PARCEL_DEPTH];
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] keep;
  logic [31:0]   pc_reg;
  logic          drop_reg;

  logic        head_is16;
  logic        avail;
  logic        accept;
  logic        load;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic [15:0] push_lo;
  logic [15:0] push_hi;

  assign head_is16   = parcel_reg[0][1:0] != 2'b11;
  assign avail       = (count_reg != '0) && (head_is16 || count_reg >= CW'(2));
  assign fetch_ready = (count_reg <= CW'(PARCEL_DEPTH - 2)) && !flush;
  assign accept      = fetch_valid && fetch_ready;
  assign load        = avail && (!out_valid || out_ready);
  assign pop_n       = !load ? 2'd0 : (head_is16 ? 2'd1 : 2'd2);
  assign push_n      = !accept ? 2'd0 : (drop_reg ? 2'd1 : 2'd2);
  // After a redirect to an odd-parcel PC the low half of the first word is skipped.
  assign push_lo     = drop_reg ? fetch_word[31:16] : fetch_word[15:0];
  assign push_hi     = fetch_word[31:16];
  assign keep        = count_reg - CW'(pop_n);
  assign count_next  = keep + CW'(push_n);

  // Slot 0 is always the head: surviving parcels shift down, new parcels land after them.
  for (genvar gi = 0; gi < PARCEL_DEPTH; gi++) begin : g_slot
    logic [15:0] nxt1;
    logic [15:0] nxt2;
    logic [15:0] shifted;
    if (gi + 1 < PARCEL_DEPTH) begin : g_n1
      assign nxt1 = parcel_reg[gi+1];
    end else begin : g_z1
      assign nxt1 = '0;
    end
    if (gi + 2 < PARCEL_DEPTH) begin : g_n2
      assign nxt2 = parcel_reg[gi+2];
    end else begin : g_z2
      assign nxt2 = '0;
    end
    assign shifted = (pop_n == 2'd2) ? nxt2 : ((pop_n == 2'd1) ? nxt1 : parcel_reg[gi]);
    assign parcel_next[gi] =
        (CW'(gi) < keep)                                     ? shifted :
        (CW'(gi) == keep && push_n != 2'd0)                  ? push_lo :
        (CW'(gi) == keep + CW'(1) && push_n == 2'd2)         ? push_hi :
                                                               parcel_reg[gi];
  end

  logic [31:0] instr;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic        f_r, f_i, f_s, f_b, f_u, f_j, opc_mem, opc_ill;
  logic [4:0]  d_r0, d_r1, d_w0;
  logic [5:0]  d_fmt, d_func;
  logic        d_mem, d_ill;

  assign instr  = head_is16 ? {16'h0000, parcel_reg[0]} : {parcel_reg[1], parcel_reg[0]};
  assign opcode = instr[6:2];
  assign funct3 = instr[14:12];

  always_comb begin
    f_r = 1'b0; f_i = 1'b0; f_s = 1'b0; f_b = 1'b0; f_u = 1'b0; f_j = 1'b0;
    opc_mem = 1'b0;
    opc_ill = 1'b0;
    case (opcode)
      5'b00100, 5'b00110, 5'b11001, 5'b11100: f_i = 1'b1;
      5'b00000: begin f_i = 1'b1; opc_mem = 1'b1; end
      5'b01101, 5'b00101: f_u = 1'b1;
      5'b11011: begin f_u = 1'b1; f_j = 1'b1; end
      5'b01100: f_r = 1'b1;
      5'b11000: begin f_s = 1'b1; f_b = 1'b1; end
      5'b01000: begin f_s = 1'b1; opc_mem = 1'b1; end
      5'b00011: ;
      default:  opc_ill = 1'b1;
    endcase
  end

  always_comb begin
    d_r0   = '0;
    d_r1   = '0;
    d_w0   = '0;
    d_fmt  = '0;
    d_func = '0;
    d_mem  = 1'b0;
    d_ill  = 1'b0;
    if (head_is16) begin
      d_ill = !ENABLE_C || (parcel_reg[0] == 16'h0000);
    end else begin
      d_r0   = f_u ? 5'd0 : instr[19:15];
      d_r1   = (f_u || f_i) ? 5'd0 : instr[24:20];
      d_w0   = f_s ? 5'd0 : instr[11:7];
      d_fmt  = {f_r, f_i, f_s, f_b, f_u, f_j};
      d_func = {opcode == 5'b11001, opcode == 5'b01101,
                instr[30] && (!f_i || funct3 == 3'b101), funct3};
      d_mem  = opc_mem;
      d_ill  = opc_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg          <= '0;
      pc_reg             <= RESET_PC;
      drop_reg           <= 1'b0;
      out_valid          <= 1'b0;
      out_pc             <= '0;
      out_instruction    <= '0;
      rf_read0_index     <= '0;
      rf_read1_index     <= '0;
      rf_write0_index    <= '0;
      instruction_format <= '0;
      func               <= '0;
      is_mem_or_io       <= 1'b0;
      is_compressed      <= 1'b0;
      is_illegal         <= 1'b0;
    end else if (flush) begin
      count_reg <= '0;
      pc_reg    <= flush_pc & ~32'h1;
      drop_reg  <= flush_pc[1];
      out_valid <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (accept) drop_reg <= 1'b0;
      if (load) begin
        out_valid          <= 1'b1;
        out_pc             <= pc_reg;
        out_instruction    <= instr;
        rf_read0_index     <= d_r0;
        rf_read1_index     <= d_r1;
        rf_write0_index    <= d_w0;
        instruction_format <= d_fmt;
        func               <= d_func;
        is_mem_or_io       <= d_mem;
        is_compressed      <= head_is16;
        is_illegal         <= d_ill;
        pc_reg             <= pc_reg + (head_is16 ? 32'd2 : 32'd4);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Parcel data needs no reset: count_reg alone defines which slots are live.
  always_ff @(posedge clk) begin
    parcel_reg <= parcel_next;
  end
endmodule

// File: tb/tb_rv32_mod_decode_stage.sv
// Self-checking bench for rv32_mod_decode_stage: directed scenarios plus a randomized
// stream checked against a queue-based reference model of the parcel buffer and decoder.
module tb_rv32_mod_decode_stage;
  localparam int D = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [4:0]  w0;
    logic [5:0]  fmt;
    logic [5:0]  fn;
    logic        mem;
    logic        comp;
    logic        ill;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n, fetch_valid, flush, out_ready;
  logic [31:0] fetch_word, flush_pc;
  logic        fetch_ready, out_valid, is_mem_or_io, is_compressed, is_illegal;
  logic [31:0] out_pc, out_instruction;
  logic [4:0]  rf_read0_index, rf_read1_index, rf_write0_index;
  logic [5:0]  instruction_format, func;
  logic        nc_fetch_ready, nc_out_valid, nc_is_mem_or_io, nc_is_compressed, nc_is_illegal;
  logic [31:0] nc_out_pc, nc_out_instruction;
  logic [4:0]  nc_rf_read0_index, nc_rf_read1_index, nc_rf_write0_index;
  logic [5:0]  nc_instruction_format, nc_func;
  dec_t        dut_dec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_mod_decode_stage #(.PARCEL_DEPTH(D), .ENABLE_C(1'b1), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_word(fetch_word), .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instruction(out_instruction),
    .rf_read0_index(rf_read0_index), .rf_read1_index(rf_read1_index),
    .rf_write0_index(rf_write0_index), .instruction_format(instruction_format),
    .func(func), .is_mem_or_io(is_mem_or_io), .is_compressed(is_compressed),
    .is_illegal(is_illegal));

  rv32_mod_decode_stage #(.PARCEL_DEPTH(D), .ENABLE_C(1'b0), .RESET_PC(32'h0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(nc_fetch_ready),
    .fetch_word(fetch_word), .flush(flush), .flush_pc(flush_pc), .out_valid(nc_out_valid),
    .out_ready(out_ready), .out_pc(nc_out_pc), .out_instruction(nc_out_instruction),
    .rf_read0_index(nc_rf_read0_index), .rf_read1_index(nc_rf_read1_index),
    .rf_write0_index(nc_rf_write0_index), .instruction_format(nc_instruction_format),
    .func(nc_func), .is_mem_or_io(nc_is_mem_or_io), .is_compressed(nc_is_compressed),
    .is_illegal(nc_is_illegal));

  assign dut_dec = {out_instruction, rf_read0_index, rf_read1_index, rf_write0_index,
                    instruction_format, func, is_mem_or_io, is_compressed, is_illegal};

  // Reference model state: parcels waiting, head PC, pending drop, and the output slot.
  bit [15:0] mq[$];
  bit [15:0] pend[$];
  bit [31:0] m_pc, m_opc;
  bit        m_drop, m_ov;
  dec_t      m_rec;
  bit [4:0]  op_tab [12] = '{5'b00100, 5'b00110, 5'b11001, 5'b11100, 5'b00000, 5'b01101,
                             5'b00101, 5'b11011, 5'b01100, 5'b11000, 5'b01000, 5'b00011};

  function automatic dec_t ref_decode(input bit [31:0] ins, input bit c);
    dec_t d;
    bit fi, fu, fs;
    bit [4:0] op;
    d = '0;
    if (c) begin
      d.instr = {16'h0, ins[15:0]};
      d.comp  = 1'b1;
      d.ill   = (ins[15:0] == 16'h0);
      return d;
    end
    op = ins[6:2];
    fi = op inside {5'b00100, 5'b00110, 5'b11001, 5'b11100, 5'b00000};
    fu = op inside {5'b01101, 5'b00101, 5'b11011};
    fs = op inside {5'b11000, 5'b01000};
    d.instr = ins;
    d.fmt   = {op == 5'b01100, fi, fs, op == 5'b11000, fu, op == 5'b11011};
    d.mem   = (op == 5'b00000) || (op == 5'b01000);
    d.ill   = !(fi || fu || fs || op == 5'b01100 || op == 5'b00011);
    d.r0    = fu ? 5'd0 : ins[19:15];
    d.r1    = (fu || fi) ? 5'd0 : ins[24:20];
    d.w0    = fs ? 5'd0 : ins[11:7];
    d.fn    = {op == 5'b11001, op == 5'b01101, ins[30] && (!fi || ins[14:12] == 3'b101), ins[14:12]};
    return d;
  endfunction

  function automatic bit model_fr();
    return (mq.size() <= D - 2) && !flush;
  endfunction

  task automatic model_update(input bit fr);
    bit c, avail;
    if (!rst_n) begin
      mq.delete(); m_pc = 32'h0; m_drop = 1'b0; m_ov = 1'b0; m_rec = '0; m_opc = 32'h0;
    end else if (flush) begin
      mq.delete(); m_pc = flush_pc & ~32'h1; m_drop = flush_pc[1]; m_ov = 1'b0;
    end else begin
      avail = (mq.size() >= 1) && ((mq[0][1:0] != 2'b11) || (mq.size() >= 2));
      if (avail && (!m_ov || out_ready)) begin
        c      = mq[0][1:0] != 2'b11;
        m_rec  = ref_decode(c ? {16'h0, mq[0]} : {mq[1], mq[0]}, c);
        m_opc  = m_pc;
        m_pc   = m_pc + (c ? 32'd2 : 32'd4);
        void'(mq.pop_front());
        if (!c) void'(mq.pop_front());
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (fetch_valid && fr) begin
        if (!m_drop) mq.push_back(fetch_word[15:0]);
        mq.push_back(fetch_word[31:16]);
        m_drop = 1'b0;
      end
    end
  endtask

  task automatic tick();
    bit fr;
    fr = model_fr();
    @(posedge clk);
    model_update(fr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fetch_word = 32'h0; flush_pc = 32'h0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic void gen_instr();
    bit [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      if (k == 0) ins[15:0] = 16'h0;
      else ins[1:0] = 2'(k - 1);
      pend.push_back(ins[15:0]);
    end else begin
      ins[1:0] = 2'b11;
      if (k < 9) ins[6:2] = op_tab[$urandom_range(0, 11)];
      pend.push_back(ins[15:0]);
      pend.push_back(ins[31:16]);
    end
  endfunction

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (dut_dec !== dec_t'(0)) begin errors++; $display("FAIL reset_dec got=%h exp=0", dut_dec); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_addi();
    out_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0051_0093;
    tick();
    fetch_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_latency got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL addi_valid_pc got=%b/%h exp=1/0", out_valid, out_pc); end
    checks++; if (dut_dec !== {32'h0051_0093, 5'd2, 5'd0, 5'd1, 6'b010000, 6'b000000, 3'b000}) begin
      errors++; $display("FAIL addi_dec got=%h exp=%h", dut_dec, {32'h0051_0093, 5'd2, 5'd0, 5'd1, 6'b010000, 6'b000000, 3'b000}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got=%b exp=0", out_valid); end
    $display("test_addi done");
  endtask

  task automatic test_sub();
    fetch_valid = 1'b1; fetch_word = 32'h4020_81B3;
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL sub_valid_pc got=%b/%h exp=1/4", out_valid, out_pc); end
    checks++; if (dut_dec !== {32'h4020_81B3, 5'd1, 5'd2, 5'd3, 6'b100000, 6'b001000, 3'b000}) begin
      errors++; $display("FAIL sub_dec got=%h exp=%h", dut_dec, {32'h4020_81B3, 5'd1, 5'd2, 5'd3, 6'b100000, 6'b001000, 3'b000}); end
    tick();
    $display("test_sub done");
  endtask

  task automatic test_straddle();
    do_reset();
    out_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0093_0001;
    tick();
    fetch_word = 32'h0000_0051;
    tick();
    fetch_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h1 || is_compressed !== 1'b1 || is_illegal !== 1'b0) begin
      errors++; $display("FAIL straddle_cnop got=%b/%h/%h/%b/%b exp=1/0/1/1/0", out_valid, out_pc, out_instruction, is_compressed, is_illegal); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2 || out_instruction !== 32'h0051_0093 || is_compressed !== 1'b0) begin
      errors++; $display("FAIL straddle_addi got=%b/%h/%h/%b exp=1/2/00510093/0", out_valid, out_pc, out_instruction, is_compressed); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h6 || is_compressed !== 1'b1 || is_illegal !== 1'b1) begin
      errors++; $display("FAIL straddle_zero got=%b/%h/%b/%b exp=1/6/1/1", out_valid, out_pc, is_compressed, is_illegal); end
    tick();
    $display("test_straddle done");
  endtask

  task automatic test_backpressure();
    int acc, n_out;
    do_reset();
    acc = 0; n_out = 0;
    out_ready = 1'b0; fetch_valid = 1'b1; fetch_word = 32'h0051_0093;
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++; if (fetch_ready !== model_fr()) begin errors++; $display("FAIL bp_fetch_ready cyc=%0d got=%b exp=%b", n, fetch_ready, model_fr()); end
      if (model_fr()) acc++;
      tick();
      checks++; if (out_valid !== m_ov || (m_ov && (dut_dec !== m_rec || out_pc !== m_opc))) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h exp=%b/%h/%h", n, out_valid, out_pc, dut_dec, m_ov, m_opc, m_rec); end
    end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", fetch_ready); end
    fetch_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (out_valid === 1'b1) begin
        n_out++;
        checks++; if (out_instruction !== 32'h0051_0093) begin errors++; $display("FAIL bp_drain_instr got=%h exp=00510093", out_instruction); end
      end
      tick();
    end
    checks++; if (n_out != acc || acc != 3) begin errors++; $display("FAIL bp_count got=%0d exp=%0d (accepted %0d)", n_out, 3, acc); end
    $display("test_backpressure done accepted=%0d delivered=%0d", acc, n_out);
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0051_0093;
    tick();
    flush = 1'b1; flush_pc = 32'h0000_0102; fetch_word = 32'hFFFF_FFFF;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", fetch_ready); end
    tick();
    flush = 1'b0; fetch_word = 32'h0001_0000;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clears got=%b exp=0", out_valid); end
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_instruction !== 32'h1 || is_compressed !== 1'b1) begin
      errors++; $display("FAIL flush_drop got=%b/%h/%h/%b exp=1/102/1/1", out_valid, out_pc, out_instruction, is_compressed); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_single got=%b exp=0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_no_compressed();
    do_reset();
    out_ready = 1'b1; fetch_valid = 1'b1; fetch_word = 32'h0000_0001;
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++; if (nc_out_valid !== 1'b1 || nc_is_compressed !== 1'b1 || nc_is_illegal !== 1'b1) begin
      errors++; $display("FAIL nc_illegal got=%b/%b/%b exp=1/1/1", nc_out_valid, nc_is_compressed, nc_is_illegal); end
    checks++; if (is_illegal !== 1'b0 || is_compressed !== 1'b1) begin errors++; $display("FAIL c_legal got=%b/%b exp=0/1", is_illegal, is_compressed); end
    out_ready = 1'b0; rst_n = 1'b0;
    tick();
    checks++; if (nc_out_valid !== 1'b0 || out_valid !== 1'b0 || nc_out_instruction !== 32'h0) begin
      errors++; $display("FAIL nc_reset got=%b/%b/%h exp=0/0/0", nc_out_valid, out_valid, nc_out_instruction); end
    rst_n = 1'b1;
    $display("test_no_compressed done");
  endtask

  task automatic test_random();
    bit acc;
    int n_tx;
    n_tx = 0;
    for (int n = 0; n < 2500; n++) begin
      fetch_valid = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      flush_pc    = $urandom;
      while (pend.size() < 2) gen_instr();
      fetch_word  = {pend[1], pend[0]};
      #1;
      acc = fetch_valid && model_fr();
      checks++; if (fetch_ready !== model_fr()) begin errors++; $display("FAIL rnd_fetch_ready cyc=%0d got=%b exp=%b", n, fetch_ready, model_fr()); end
      if (out_valid === 1'b1 && out_ready) n_tx++;
      tick();
      if (acc) begin void'(pend.pop_front()); void'(pend.pop_front()); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (dut_dec !== m_rec || out_pc !== m_opc) begin
          errors++; $display("FAIL rnd_out cyc=%0d got=%h pc=%h exp=%h pc=%h", n, dut_dec, out_pc, m_rec, m_opc); end
      end
    end
    flush = 1'b0; fetch_valid = 1'b0;
    $display("test_random done instructions=%0d", n_tx);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_straddle();
    test_backpressure();
    test_flush();
    test_no_compressed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
